cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multi-cycle control FSM for the 8-bit core: fetches 16-bit instructions from program memory over a req/ack handshake, holds them in the instruction register that feeds the decoder, and commits the decoder's results. It commits register-file writes, latches ALU status and updates the program counter. It also provides run/single-step/halt control for bring-up and debug.

## Interface
- PC_WIDTH, 8, program counter / instruction address width
- PROGRAM_DataWidth, 16, instruction width
- NumOpCodeBits, 5, opcode field width, located at IR[15:11]
- NumStatusBits, 3, ALU status width
- RESET_PC, 0, PC value after reset

- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- run  in  1  level; 1 = continuous execution
- step  in  1  one-cycle pulse; executes exactly one instruction when idle
- imem_req  out  1  fetch request
- imem_addr  out  PC_WIDTH  fetch address; equals pc
- imem_ack  in  1  fetch complete; imem_data valid in the same cycle
- imem_data  in  PROGRAM_DataWidth  fetched instruction
- instruction  out  PROGRAM_DataWidth  instruction register, drives the decoder
- dec_wr_en  in  1  decoder register-write request
- dec_sel_alu  in  1  decoder sel_reg_in_alu_decoder (1 = ALU result)
- dec_cnt_wr_en  in  1  decoder branch-taken / PC load
- dec_literal_adr  in  PC_WIDTH  branch target
- alu_status  in  NumStatusBits  ALU status flags
- status  out  NumStatusBits  latched status, fed back to the decoder
- rf_wr_en  out  1  register-file write strobe
- pc  out  PC_WIDTH  program counter
- halted  out  1  1 while in IDLE
- instr_done  out  1  one-cycle pulse per committed instruction
- illegal_op  out  1  one-cycle pulse in EXEC for a reserved opcode

## Operation
- States: IDLE, FETCH, DECODE, EXEC.
- IDLE: halted=1, imem_req=0.
  - run=1 -> FETCH.
  - run=0 and step=1 -> FETCH, with the single-step flag set.
- FETCH: imem_req=1, imem_addr=pc, held steady until imem_ack.
  - On imem_ack: instruction<=imem_data; imem_req drops the next cycle; -> DECODE.
- DECODE: one cycle for the combinational decoder to settle. No state updates. -> EXEC.
- EXEC: commit.
  - rf_wr_en = dec_wr_en, unless the opcode is reserved.
  - If dec_wr_en & dec_sel_alu: status<=alu_status.
  - If dec_cnt_wr_en: pc<=dec_literal_adr; else pc<=pc+1.
  - instr_done=1.
  - Next state: run=1 and single-step flag clear -> FETCH; otherwise -> IDLE. The single-step flag clears here.
- Reserved opcodes: 01010-01111 and 10110-11111.
  - rf_wr_en forced 0, status unchanged, pc<=pc+1, illegal_op=1.
- NOP (00000): no write, pc+1.
- step is ignored outside IDLE.
- step while run=1 in IDLE behaves as run.

## Timing
- Reset (async) values:
  - state=IDLE, pc=RESET_PC, instruction=0, status=0.
  - imem_req, rf_wr_en, instr_done and illegal_op are 0.
  - halted=1.
  - imem_req drops combinationally with rst.
- Zero-wait memory (imem_ack in the first FETCH cycle): 3 cycles per instruction (FETCH, DECODE, EXEC). Each wait cycle on imem_ack adds 1.
- In EXEC, rf_wr_en, instr_done and illegal_op are asserted for exactly that cycle. pc and status update on the EXEC->next edge.
- The new pc is visible on imem_addr in the following FETCH.
- PC wraps: 8'hFF + 1 -> 8'h00, with no flag.
- A branch to the current pc is legal and loops.
- run deasserted mid-instruction: the instruction completes, then IDLE. No abort.
- run asserted in IDLE: FETCH on the next edge.
- rst during FETCH with a pending ack: the ack is ignored, instruction stays 0.

## Test plan
- Reset, then run=1, zero-wait memory with ADD at addr 0 and SUB at addr 1 -> imem_addr 0,1,2 on cycles 1,4,7; instr_done every 3rd cycle; rf_wr_en one cycle per instruction.
- GOTO 8'h3F at pc=0x10 with dec_cnt_wr_en=1 -> next imem_addr=0x3F; rf_wr_en=0. Then pc=0xFF with a NOP -> next fetch at 0x00.
- imem_ack delayed 4 cycles -> imem_req and imem_addr stable throughout; instruction latched only on the ack cycle; 7 cycles total.
- run=0, step pulse in IDLE -> exactly one instr_done, return to IDLE, halted=1. A step pulse mid-FETCH -> ignored.
- Reserved opcode 01010 with dec_wr_en=1 -> rf_wr_en=0, illegal_op=1 for one cycle, pc+1, status unchanged.
- ADD with alu_status=3'b101 -> status=3'b101 after EXEC. VAL (dec_sel_alu=0) -> status held. rst asserted mid-DECODE -> IDLE, pc=0, outputs at reset values immediately.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Instruction sequencer for the 8-bit core: fetch over req/ack, decode settle, commit.
// Provides run / single-step / halt control for bring-up.
//
// state  | meaning
// IDLE   | halted, waiting for run or a step pulse
// FETCH  | imem_req held with pc on imem_addr until imem_ack
// DECODE | instruction register stable, decoder settling
// EXEC   | commit rf write, status, pc; pick next state
module cpu_sequencer #(
  parameter int                  PC_WIDTH          = 8,
  parameter int                  PROGRAM_DataWidth = 16,
  parameter int                  NumOpCodeBits     = 5,
  parameter int                  NumStatusBits     = 3,
  parameter logic [PC_WIDTH-1:0] RESET_PC          = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         run,
  input  logic                         step,
  output logic                         imem_req,
  output logic [PC_WIDTH-1:0]          imem_addr,
  input  logic                         imem_ack,
  input  logic [PROGRAM_DataWidth-1:0] imem_data,
  output logic [PROGRAM_DataWidth-1:0] instruction,
  input  logic                         dec_wr_en,
  input  logic                         dec_sel_alu,
  input  logic                         dec_cnt_wr_en,
  input  logic [PC_WIDTH-1:0]          dec_literal_adr,
  input  logic [NumStatusBits-1:0]     alu_status,
  output logic [NumStatusBits-1:0]     status,
  output logic                         rf_wr_en,
  output logic [PC_WIDTH-1:0]          pc,
  output logic                         halted,
  output logic                         instr_done,
  output logic                         illegal_op
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_DECODE = 2'd2,
    S_EXEC   = 2'd3
  } state_t;

  localparam logic [NumOpCodeBits-1:0] RSV_A_LO = NumOpCodeBits'(5'b01010);
  localparam logic [NumOpCodeBits-1:0] RSV_A_HI = NumOpCodeBits'(5'b01111);
  localparam logic [NumOpCodeBits-1:0] RSV_B_LO = NumOpCodeBits'(5'b10110);

  state_t                   state;
  logic                     req_q;
  logic                     single_step;
  logic [NumOpCodeBits-1:0] opcode;
  logic                     reserved;

  assign opcode   = instruction[PROGRAM_DataWidth-1 -: NumOpCodeBits];
  assign reserved = ((opcode >= RSV_A_LO) && (opcode <= RSV_A_HI)) || (opcode >= RSV_B_LO);

  // The request must vanish the moment reset is applied, not at the next edge.
  assign imem_req  = req_q & ~rst;
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      instruction <= '0;
      status      <= '0;
      req_q       <= 1'b0;
      rf_wr_en    <= 1'b0;
      instr_done  <= 1'b0;
      illegal_op  <= 1'b0;
      halted      <= 1'b1;
      single_step <= 1'b0;
    end else begin
      rf_wr_en   <= 1'b0;
      instr_done <= 1'b0;
      illegal_op <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run || step) begin
            state       <= S_FETCH;
            req_q       <= 1'b1;
            halted      <= 1'b0;
            single_step <= ~run;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            instruction <= imem_data;
            req_q       <= 1'b0;
            state       <= S_DECODE;
          end
        end
        S_DECODE: begin
          // The decoder is a pure function of the held instruction, so its
          // write request is already final here; registering it gives a clean
          // single-cycle strobe aligned with EXEC.
          state      <= S_EXEC;
          rf_wr_en   <= dec_wr_en & ~reserved;
          instr_done <= 1'b1;
          illegal_op <= reserved;
        end
        S_EXEC: begin
          if (dec_wr_en && dec_sel_alu && !reserved) begin
            status <= alu_status;
          end
          if (dec_cnt_wr_en && !reserved) begin
            pc <= dec_literal_adr;
          end else begin
            pc <= pc + PC_WIDTH'(1);
          end
          single_step <= 1'b0;
          if (run && !single_step) begin
            state <= S_FETCH;
            req_q <= 1'b1;
          end else begin
            state  <= S_IDLE;
            halted <= 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          req_q  <= 1'b0;
          halted <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: directed program, commit monitor checks
// strobes, latency, and the pc/status that follow each commit.
module tb_cpu_sequencer;

  logic        clk;
  logic        rst;
  logic        run;
  logic        step;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [15:0] instruction;
  logic        dec_wr_en;
  logic        dec_sel_alu;
  logic        dec_cnt_wr_en;
  logic [7:0]  dec_literal_adr;
  logic [2:0]  alu_status;
  logic [2:0]  status;
  logic        rf_wr_en;
  logic [7:0]  pc;
  logic        halted;
  logic        instr_done;
  logic        illegal_op;

  cpu_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .step(step),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .instruction(instruction), .dec_wr_en(dec_wr_en), .dec_sel_alu(dec_sel_alu),
    .dec_cnt_wr_en(dec_cnt_wr_en), .dec_literal_adr(dec_literal_adr), .alu_status(alu_status),
    .status(status), .rf_wr_en(rf_wr_en), .pc(pc), .halted(halted),
    .instr_done(instr_done), .illegal_op(illegal_op)
  );

  localparam logic [15:0] I_ADD  = 16'h0805;  // status 101
  localparam logic [15:0] I_SUB  = 16'h1002;  // status 010
  localparam logic [15:0] I_VAL  = 16'h1807;  // register write, not from ALU
  localparam logic [15:0] I_RSV  = 16'h507B;  // opcode 01010, also requests a jump
  localparam logic [15:0] I_NOP  = 16'h0000;

  typedef struct {
    logic       rf;
    logic       ill;
    int         lat;
    logic [7:0] pc_next;
    logic [2:0] st_next;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mem [256];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_done   = 0;
  int          cyc      = 0;
  int          ack_delay = 0;

  // Stand-in decoder/ALU: a function of the instruction register only.
  always_comb begin
    dec_wr_en       = 1'b0;
    dec_sel_alu     = 1'b0;
    dec_cnt_wr_en   = 1'b0;
    dec_literal_adr = instruction[7:0];
    alu_status      = instruction[2:0];
    case (instruction[15:11])
      5'b00001, 5'b00010: begin dec_wr_en = 1'b1; dec_sel_alu = 1'b1; end
      5'b00011:           dec_wr_en = 1'b1;
      5'b00100:           dec_cnt_wr_en = 1'b1;
      5'b01010: begin dec_wr_en = 1'b1; dec_sel_alu = 1'b1; dec_cnt_wr_en = 1'b1; end
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input logic rf, input logic ill, input int lat,
                      input logic [7:0] pcn, input logic [2:0] stn);
    exp_t e;
    e.rf = rf; e.ill = ill; e.lat = lat; e.pc_next = pcn; e.st_next = stn;
    exp_q.push_back(e);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Program memory responder: ack after ack_delay wait cycles.
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    imem_ack  = 1'b0;
    imem_data = '0;
    forever begin
      @(negedge clk);
      if (imem_req && wait_cnt == ack_delay) begin
        imem_ack  = 1'b1;
        imem_data = mem[imem_addr];
        wait_cnt  = 0;
      end else begin
        imem_ack  = 1'b0;
        imem_data = 16'hDEAD;
        wait_cnt  = imem_req ? wait_cnt + 1 : 0;
      end
    end
  end

  // Commit monitor.
  initial begin
    logic       pend;
    logic       prev_req;
    int         fetch_start;
    logic [7:0] pend_pc;
    logic [2:0] pend_st;
    exp_t       e;
    pend = 1'b0; prev_req = 1'b0; fetch_start = 0; pend_pc = '0; pend_st = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0;
        prev_req = 1'b0;
        continue;
      end
      if (pend) begin
        check("pc_after_commit", imem_addr, pend_pc);
        check("status_after_commit", status, pend_st);
        pend = 1'b0;
      end
      if (imem_req && !prev_req) fetch_start = cyc;
      prev_req = imem_req;
      if (instr_done) begin
        n_done++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_commit: commit at pc %0h with nothing expected", pc);
        end else begin
          e = exp_q.pop_front();
          check("rf_wr_en", rf_wr_en, e.rf);
          check("illegal_op", illegal_op, e.ill);
          check("commit_latency", cyc - fetch_start, e.lat);
          pend    = 1'b1;
          pend_pc = e.pc_next;
          pend_st = e.st_next;
        end
      end else begin
        check("strobes_outside_exec", {rf_wr_en, illegal_op}, 0);
      end
    end
  end

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (halted && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
    check(name, {ok, halted}, 2'b11);
  endtask

  initial begin
    int  done_before;
    bit  found;
    rst = 1'b1; run = 1'b0; step = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = I_NOP;
    mem[8'h00] = I_ADD;
    mem[8'h01] = I_SUB;
    mem[8'h02] = 16'h2010;
    mem[8'h10] = 16'h203F;
    mem[8'h3F] = I_VAL;
    mem[8'h40] = I_RSV;
    mem[8'h41] = 16'h20FF;
    mem[8'hFF] = I_NOP;

    repeat (2) @(negedge clk);
    check("reset_imem_req", imem_req, 1'b0);
    check("reset_halted", halted, 1'b1);
    check("reset_pc", pc, 8'h00);
    check("reset_instruction", instruction, 16'h0000);
    check("reset_status", status, 3'b000);
    check("reset_strobes", {rf_wr_en, instr_done, illegal_op}, 3'b000);
    rst = 1'b0;
    @(negedge clk);
    check("idle_without_run", {halted, imem_req}, 2'b10);

    // Continuous run, zero-wait memory.
    push(1'b1, 1'b0, 2, 8'h01, 3'b101);  // ADD
    push(1'b1, 1'b0, 2, 8'h02, 3'b010);  // SUB
    push(1'b0, 1'b0, 2, 8'h10, 3'b010);  // GOTO 10
    push(1'b0, 1'b0, 2, 8'h3F, 3'b010);  // GOTO 3F
    push(1'b1, 1'b0, 2, 8'h40, 3'b010);  // VAL: status held
    push(1'b0, 1'b1, 2, 8'h41, 3'b010);  // reserved: no write, no jump
    push(1'b0, 1'b0, 2, 8'hFF, 3'b010);  // GOTO FF
    push(1'b0, 1'b0, 2, 8'h00, 3'b010);  // NOP wraps to 00
    run = 1'b1;
    @(negedge clk);
    check("fetch_after_run", {imem_req, halted, imem_addr}, {2'b10, 8'h00});
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 8'hFF) begin
        found = 1'b1;
        break;
      end
    end
    check("reached_pc_ff", found, 1'b1);
    run = 1'b0;  // NOP must still complete
    wait_idle("idle_after_run_drop");
    check("pc_wrapped", pc, 8'h00);

    // Single step with a 4-cycle wait on the fetch; a second step mid-FETCH is ignored.
    done_before = n_done;
    ack_delay = 4;
    push(1'b1, 1'b0, 6, 8'h01, 3'b101);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("wait_req_addr_stable", {imem_req, imem_addr}, {1'b1, 8'h00});
      check("wait_instruction_held", instruction, I_NOP);
      step = (i == 1);
      @(negedge clk);
    end
    step = 1'b0;
    check("ack_cycle_instruction_held", instruction, I_NOP);
    @(negedge clk);
    check("instruction_latched", instruction, I_ADD);
    wait_idle("idle_after_step");
    check("single_commit_per_step", n_done - done_before, 1);

    // Reset in DECODE.
    ack_delay = 0;
    done_before = n_done;
    run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("decode_before_reset", {imem_req, halted, instruction}, {2'b00, I_SUB});
    rst = 1'b1;
    #1;
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_halted", halted, 1'b1);
    check("rst_pc", pc, 8'h00);
    check("rst_instr_status", {instruction, status}, 19'h0);
    check("rst_strobes", {rf_wr_en, instr_done, illegal_op}, 3'b000);
    run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("no_commit_after_reset", n_done - done_before, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
